// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the instruction memory. A program image arrives as a
//   byte stream: a 16-bit little-endian word count N, N*4 payload bytes (each
//   word least-significant byte first), then one checksum byte equal to the
//   XOR of every preceding frame byte. Words are written through the
//   instruction-memory write port, and the core is held in reset until the
//   whole image has been loaded and its checksum matched.
//
// Ports
//   clk         single clock, everything rises on posedge
//   rst         synchronous active-low reset
//   in_valid    byte source has a byte
//   in_data     byte value
//   in_ready    loader accepts a byte this cycle
//   imem_we     one-cycle write strobe
//   imem_waddr  byte address of the written word (BASE_ADDR + 4*k)
//   imem_wdata  assembled word
//   core_hold   holds the core in reset until successful completion
//   done        image loaded, checksum matched (sticky until reset)
//   error       load failed (sticky until reset)
//   dbg_state   current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are
// both high. in_ready depends only on loader state, never on in_valid, and
// in_valid/in_data are expected to stay stable until the transfer occurs.
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_run;      // 0 while in reset, 1 from the first cycle after release
   logic [15:0] r_len;
   logic [15:0] r_k;
   logic [1:0]  r_lane;
   logic [23:0] r_buf;      // lanes 0..2 of the word being assembled
   logic [7:0]  r_xor;
   logic [15:0] r_idle;
   logic        r_we;
   logic [31:0] r_waddr;
   logic [31:0] r_wdata;

   logic        w_loading;
   logic        w_counting;
   logic        w_accept;
   logic        w_timeout;
   logic [15:0] w_len_full;

   assign w_loading  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
   // LEN0 waits forever for a frame to start; only mid-frame states time out.
   assign w_counting = (r_state == S_LEN1) || (r_state == S_DATA) ||
                       (r_state == S_CSUM);
   assign in_ready   = r_run & w_loading;
   assign w_accept   = in_valid & in_ready;
   assign w_len_full = {in_data, r_len[7:0]};
   // An accepted byte always beats an expiring timeout.
   assign w_timeout  = (TIMEOUT != 0) && w_counting && !w_accept &&
                       (r_idle == 16'(TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LEN0: begin
            if (w_accept) w_next = S_LEN1;
         end
         S_LEN1: begin
            if (w_accept) begin
               if (32'(w_len_full) > MAX_WORDS) w_next = S_ERR;
               else if (w_len_full == 16'd0)    w_next = S_CSUM;
               else                             w_next = S_DATA;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_DATA: begin
            if (w_accept) begin
               if ((r_lane == 2'd3) && (r_k == r_len - 16'd1)) w_next = S_CSUM;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_CSUM: begin
            if (w_accept)       w_next = (in_data == r_xor) ? S_DONE : S_ERR;
            else if (w_timeout) w_next = S_ERR;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_LEN0;
         r_run   <= 1'b0;
         r_len   <= 16'd0;
         r_k     <= 16'd0;
         r_lane  <= 2'd0;
         r_buf   <= 24'd0;
         r_xor   <= 8'd0;
         r_idle  <= 16'd0;
         r_we    <= 1'b0;
         r_waddr <= BASE_ADDR;
         r_wdata <= 32'd0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
         r_we    <= 1'b0;
         if (w_accept) begin
            r_idle <= 16'd0;
            r_xor  <= r_xor ^ in_data;
         end else if (w_counting) begin
            r_idle <= r_idle + 16'd1;
         end
         if (w_accept) begin
            case (r_state)
               S_LEN0: r_len[7:0]  <= in_data;
               S_LEN1: r_len[15:8] <= in_data;
               S_DATA: begin
                  r_lane <= r_lane + 2'd1;
                  case (r_lane)
                     2'd0: r_buf[7:0]   <= in_data;
                     2'd1: r_buf[15:8]  <= in_data;
                     2'd2: r_buf[23:16] <= in_data;
                     default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {in_data, r_buf};
                        r_waddr <= BASE_ADDR + {14'd0, r_k, 2'b00};
                        r_k     <= r_k + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_waddr = r_waddr;
   assign imem_wdata = r_wdata;
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERR);
   assign core_hold  = (r_state != S_DONE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;

   logic [1:0]        o_rdy, o_we, o_hold, o_done, o_err;
   logic [1:0][31:0]  o_addr, o_wdata;
   logic [1:0][2:0]   o_st;

   // u0: base 0, small word limit, short timeout. u1: relocated base, default
   // limit, timeout disabled. Both see the same byte stream.
   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4), .TIMEOUT(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(o_rdy[0]), .imem_we(o_we[0]), .imem_waddr(o_addr[0]),
      .imem_wdata(o_wdata[0]), .core_hold(o_hold[0]), .done(o_done[0]),
      .error(o_err[0]), .dbg_state(o_st[0]));

   imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(1024), .TIMEOUT(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(o_rdy[1]), .imem_we(o_we[1]), .imem_waddr(o_addr[1]),
      .imem_wdata(o_wdata[1]), .core_hold(o_hold[1]), .done(o_done[1]),
      .error(o_err[1]), .dbg_state(o_st[1]));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (frame-position based) ----------------
   logic [31:0] p_base[2];
   int          p_max[2];
   int          p_to[2];

   bit          m_run[2];
   int          m_cnt[2];   // frame bytes accepted so far
   int          m_n[2];
   logic [7:0]  m_xor[2];
   int          m_stat[2];  // 0 loading, 1 done, 2 error
   int          m_idle[2];
   bit          m_we[2];
   logic [31:0] m_addr[2];
   logic [31:0] m_wdata[2];
   logic [31:0] m_buf[2];

   task automatic model_edge(input int i);
      bit acc;
      int p, b;
      if (!rst) begin
         m_run[i] = 0; m_cnt[i] = 0; m_n[i] = 0; m_xor[i] = 8'h00;
         m_stat[i] = 0; m_idle[i] = 0; m_we[i] = 0;
         m_addr[i] = p_base[i]; m_wdata[i] = 32'h0; m_buf[i] = 32'h0;
      end else begin
         acc = in_valid && m_run[i] && (m_stat[i] == 0);
         m_we[i] = 0;
         if (m_stat[i] == 0) begin
            if (acc) begin
               p = m_cnt[i];
               m_idle[i] = 0;
               if (p == 0) begin
                  m_n[i] = int'(in_data);
               end else if (p == 1) begin
                  m_n[i] = m_n[i] + 256 * int'(in_data);
                  if (m_n[i] > p_max[i]) m_stat[i] = 2;
               end else if (p < 2 + 4 * m_n[i]) begin
                  b = p - 2;
                  m_buf[i] = {in_data, m_buf[i][31:8]};
                  if (b % 4 == 3) begin
                     m_we[i]    = 1;
                     m_addr[i]  = p_base[i] + 32'(4 * (b / 4));
                     m_wdata[i] = m_buf[i];
                  end
               end else begin
                  m_stat[i] = (in_data == m_xor[i]) ? 1 : 2;
               end
               m_xor[i] = m_xor[i] ^ in_data;
               m_cnt[i] = m_cnt[i] + 1;
            end else if (m_cnt[i] > 0) begin
               m_idle[i] = m_idle[i] + 1;
               if (p_to[i] != 0 && m_idle[i] == p_to[i]) m_stat[i] = 2;
            end
         end
         m_run[i] = 1;
      end
   endtask

   task automatic model_check(input int i);
      chk($sformatf("u%0d in_ready", i),   32'(o_rdy[i]),  32'(m_run[i] && m_stat[i] == 0));
      chk($sformatf("u%0d imem_we", i),    32'(o_we[i]),   32'(m_we[i]));
      chk($sformatf("u%0d imem_waddr", i), o_addr[i],      m_addr[i]);
      chk($sformatf("u%0d imem_wdata", i), o_wdata[i],     m_wdata[i]);
      chk($sformatf("u%0d done", i),       32'(o_done[i]), 32'(m_stat[i] == 1));
      chk($sformatf("u%0d error", i),      32'(o_err[i]),  32'(m_stat[i] == 2));
      chk($sformatf("u%0d core_hold", i),  32'(o_hold[i]), 32'(m_stat[i] != 1));
   endtask

   // One clock: inputs already set; model follows the edge, outputs sampled on negedge.
   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      model_check(0);
      model_check(1);
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      step(); step();
      rst = 1'b1;
      step();
   endtask

   // ---------------- frame construction and sending ----------------
   logic [7:0] frame_q[$];

   task automatic build_frame(input int n, input bit bad);
      logic [7:0] x;
      logic [7:0] byte_v;
      frame_q.delete();
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      for (int w = 0; w < 4 * n; w++) begin
         byte_v = 8'($urandom_range(0, 255));
         frame_q.push_back(byte_v);
      end
      x = 8'h00;
      foreach (frame_q[j]) x = x ^ frame_q[j];
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      frame_q.push_back(x);
   endtask

   // Sends frame bytes [from, to) with random idle gaps of up to max_gap cycles.
   task automatic send_range(input int from, input int to, input int max_gap);
      int gap;
      for (int j = from; j < to; j++) begin
         gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         repeat (gap) drive(1'b0, 8'($urandom_range(0, 255)));
         drive(1'b1, frame_q[j]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        r;
      logic        v;
      logic [7:0]  d;
      logic        e_rdy;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                               input logic e_rdy, input logic e_we,
                               input logic [31:0] e_addr, input logic [31:0] e_data,
                               input logic e_done, input logic e_err);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.e_rdy = e_rdy; t.e_we = e_we;
      t.e_addr = e_addr; t.e_data = e_data; t.e_done = e_done; t.e_err = e_err;
      return t;
   endfunction

   initial begin
      p_base[0] = 32'h0000_0000; p_max[0] = 4;    p_to[0] = 8;
      p_base[1] = 32'h0000_0100; p_max[1] = 1024; p_to[1] = 0;

      // N=2 frame: words 0x00000093, 0x00100113; checksum is the XOR of the
      // ten preceding bytes, 0x93.
      tbl[0]  = mk(0, 0, 8'h00, 0, 0, 32'h0, 32'h0,         0, 0);
      tbl[1]  = mk(1, 0, 8'h00, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[2]  = mk(1, 1, 8'h02, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[3]  = mk(1, 1, 8'h00, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[4]  = mk(1, 1, 8'h93, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[5]  = mk(1, 1, 8'h00, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[6]  = mk(1, 1, 8'h00, 1, 0, 32'h0, 32'h0,         0, 0);
      tbl[7]  = mk(1, 1, 8'h00, 1, 1, 32'h0, 32'h0000_0093, 0, 0);
      tbl[8]  = mk(1, 1, 8'h13, 1, 0, 32'h0, 32'h0000_0093, 0, 0);
      tbl[9]  = mk(1, 1, 8'h01, 1, 0, 32'h0, 32'h0000_0093, 0, 0);
      tbl[10] = mk(1, 1, 8'h10, 1, 0, 32'h0, 32'h0000_0093, 0, 0);
      tbl[11] = mk(1, 1, 8'h00, 1, 1, 32'h4, 32'h0010_0113, 0, 0);
      tbl[12] = mk(1, 1, 8'h93, 0, 0, 32'h4, 32'h0010_0113, 1, 0);
      tbl[13] = mk(1, 0, 8'h00, 0, 0, 32'h4, 32'h0010_0113, 1, 0);

      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].r;
         drive(tbl[i].v, tbl[i].d);
         chk($sformatf("tbl[%0d] in_ready", i),  32'(o_rdy[0]),  32'(tbl[i].e_rdy));
         chk($sformatf("tbl[%0d] imem_we", i),   32'(o_we[0]),   32'(tbl[i].e_we));
         chk($sformatf("tbl[%0d] imem_waddr", i), o_addr[0],     tbl[i].e_addr);
         chk($sformatf("tbl[%0d] imem_wdata", i), o_wdata[0],    tbl[i].e_data);
         chk($sformatf("tbl[%0d] done", i),      32'(o_done[0]), 32'(tbl[i].e_done));
         chk($sformatf("tbl[%0d] error", i),     32'(o_err[0]),  32'(tbl[i].e_err));
         chk($sformatf("tbl[%0d] core_hold", i), 32'(o_hold[0]), 32'(!tbl[i].e_done));
      end

      // Same frame with a wrong checksum: both words written, then error.
      do_reset();
      frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h01, 8'h10, 8'h00, 8'h90};
      send_range(0, frame_q.size(), 0);
      idle(2);
      chk("bad csum error", 32'(o_err[0]), 32'd1);
      chk("bad csum hold",  32'(o_hold[0]), 32'd1);

      // Empty image.
      do_reset();
      frame_q = '{8'h00, 8'h00, 8'h00};
      send_range(0, 3, 0);
      chk("n0 done", 32'(o_done[0]), 32'd1);
      idle(2);

      // N=5 is above u0's limit but fine for u1.
      do_reset();
      build_frame(5, 0);
      send_range(0, frame_q.size(), 0);
      idle(2);
      chk("n5 u0 error", 32'(o_err[0]), 32'd1);
      chk("n5 u1 done",  32'(o_done[1]), 32'd1);

      // Random gaps up to 7 idle cycles in 3-word frames.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         build_frame(3, 0);
         send_range(0, frame_q.size(), 7);
         idle(2);
         chk("gap u0 done", 32'(o_done[0]), 32'd1);
      end

      // Stall 7 (tolerated), then stall 8 in DATA (u0 errors, u1 carries on).
      do_reset();
      build_frame(3, 0);
      send_range(0, 5, 0);
      idle(7);
      send_range(5, 8, 0);
      idle(8);
      chk("stall u0 error", 32'(o_err[0]), 32'd1);
      send_range(8, frame_q.size(), 0);
      idle(2);
      chk("stall u1 done", 32'(o_done[1]), 32'd1);

      // Reset after 6 payload bytes, then a complete 1-word frame.
      do_reset();
      build_frame(2, 0);
      send_range(0, 8, 0);
      do_reset();
      build_frame(1, 0);
      send_range(0, 5, 0);
      in_valid = 1'b1; in_data = frame_q[5];
      @(posedge clk);
      model_edge(0); model_edge(1);
      @(negedge clk);
      model_check(0); model_check(1);
      chk("rst u1 strobe", 32'(o_we[1]), 32'd1);
      chk("rst u1 addr",   o_addr[1], 32'h0000_0100);
      send_range(6, frame_q.size(), 0);
      idle(2);
      chk("rst u1 done", 32'(o_done[1]), 32'd1);

      // Random frames: length 0..6, random checksum corruption and gaps.
      for (int r = 0; r < 20; r++) begin
         do_reset();
         build_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
         send_range(0, frame_q.size(), $urandom_range(0, 7));
         idle(3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
